// File: rtl/paralelo_serial_tx.sv
// rtl/paralelo_serial_tx.sv - byte-parallel to MSB-first serial transmitter with comma fill
// Optional SYNC comma preamble is enabled by defining macro PS_TX_SYNC_PREAMBLE_EN.
module paralelo_serial_tx #(
    parameter logic [7:0]  COMMA       = 8'hBC,
    parameter int unsigned SYNC_COMMAS = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       active_out,
    output logic       byte_strobe
);

`ifdef PS_TX_SYNC_PREAMBLE_EN
    localparam bit LP_PREAMBLE_EN = 1'b1;
`else
    localparam bit LP_PREAMBLE_EN = 1'b0;
`endif
    localparam logic [3:0] LP_LAST_COMMA = SYNC_COMMAS[3:0];

    typedef enum logic {ST_SYNC, ST_ACTIVE} state_t;

    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_comma_cnt;
    logic [7:0] r_fifo_0;
    logic [7:0] r_fifo_1;
    logic [1:0] r_fifo_cnt;
    logic [7:0] r_shift;
    logic       r_data_out;
    logic       r_strobe;
    logic       r_active;

    logic       w_boundary;
    logic       w_go_active;
    logic       w_push;
    logic       w_pop;
    logic [7:0] w_next_byte;

    // r_comma_cnt counts commas already started, so the boundary that ends the last one
    // is the first boundary where the count has reached SYNC_COMMAS.
    assign w_boundary  = (r_bit_cnt == 3'd7);
    assign w_go_active = (r_state == ST_ACTIVE) ||
                         (w_boundary && (r_comma_cnt == LP_LAST_COMMA));
    assign ready_out   = !reset && (r_fifo_cnt != 2'd2);
    assign w_push      = valid_in && ready_out;
    assign w_pop       = w_boundary && w_go_active && (r_fifo_cnt != 2'd0);
    assign w_next_byte = w_pop ? r_fifo_0 : COMMA;

    assign data_out    = r_data_out;
    assign byte_strobe = r_strobe;
    assign active_out  = r_active;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_state     <= LP_PREAMBLE_EN ? ST_SYNC : ST_ACTIVE;
            r_bit_cnt   <= 3'd7;
            r_comma_cnt <= 4'd0;
            r_fifo_0    <= 8'd0;
            r_fifo_1    <= 8'd0;
            r_fifo_cnt  <= 2'd0;
            r_shift     <= 8'd0;
            r_data_out  <= 1'b0;
            r_strobe    <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_strobe  <= w_boundary;
            r_active  <= w_go_active;

            if (w_boundary) begin
                r_shift    <= {w_next_byte[6:0], 1'b0};
                r_data_out <= w_next_byte[7];
                if (r_state == ST_SYNC) begin
                    if (w_go_active) begin
                        r_state <= ST_ACTIVE;
                    end else begin
                        r_comma_cnt <= r_comma_cnt + 4'd1;
                    end
                end
            end else begin
                r_shift    <= {r_shift[6:0], 1'b0};
                r_data_out <= r_shift[7];
            end

            case ({w_push, w_pop})
                2'b10: begin
                    if (r_fifo_cnt == 2'd0) begin
                        r_fifo_0 <= data_in;
                    end else begin
                        r_fifo_1 <= data_in;
                    end
                    r_fifo_cnt <= r_fifo_cnt + 2'd1;
                end
                2'b01: begin
                    r_fifo_0   <= r_fifo_1;
                    r_fifo_cnt <= r_fifo_cnt - 2'd1;
                end
                // Push and pop together only happen at occupancy 1: new byte takes the head.
                2'b11: r_fifo_0 <= data_in;
                default: ;
            endcase
        end
    end

endmodule
